multdiv_unit: RTL

//  Iterative signed 32-bit multiplier/divider in the processor execute stage.

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_iter_counter.sv | 31 +++
 rtl/multdiv_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package multdiv_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } state_t;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: counts RUN cycles and flags the final iteration.
module multdiv_iter_counter
   import multdiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_count,
   output logic          o_last
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_count = r_count;
   assign o_last  = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (shift-add) / divider (restoring), one step per clock,
// working on operand magnitudes with a sign fix-up on the final iteration.
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      r_op;
   logic                      r_neg;
   logic                      r_b_zero;
   logic                      r_ovf;
   logic [WIDTH-1:0]          r_mag_a;
   logic [WIDTH-1:0]          r_mag_b;
   logic [WIDTH:0]            r_rem;
   logic [WIDTH-1:0]          r_quo;
   logic [WIDTH-1:0]          r_result;
   logic                      r_exc;

   logic                      w_start;
   logic                      w_op_in;
   logic                      w_last;
   logic [CW-1:0]             w_count;
   logic [WIDTH:0]            w_sum;
   logic [WIDTH:0]            w_shift;
   logic [WIDTH+1:0]          w_sub;
   logic [WIDTH:0]            w_rem_nxt;
   logic [WIDTH-1:0]          w_quo_nxt;
   logic [2*WIDTH-1:0]        w_prod_mag;
   logic signed [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]          w_quo_s;
   logic [WIDTH-1:0]          w_res_fin;
   logic                      w_exc_fin;

   // Widened by one bit so that -2^(WIDTH-1) has a representable magnitude.
   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] v_ext;
      v_ext = {v[WIDTH-1], v};
      if (v[WIDTH-1]) begin
         v_ext = -v_ext;
      end
      return v_ext[WIDTH-1:0];
   endfunction

   assign w_start = ctrl_MULT | ctrl_DIV;
   assign w_op_in = ctrl_MULT ? OP_MULT : OP_DIV;

   multdiv_iter_counter #(.WIDTH(WIDTH)) u_counter (
      .clk     (clk),
      .rst_n   (reset),
      .i_clr   (w_start),
      .i_en    (r_state == ST_RUN),
      .o_count (w_count),
      .o_last  (w_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A start pulse always (re)launches, aborting whatever was in flight.
   always_comb begin
      w_state_nxt    = r_state;
      busy           = 1'b0;
      data_resultRDY = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (w_start)     w_state_nxt = ST_RUN;
            else if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            data_resultRDY = 1'b1;
            w_state_nxt    = w_start ? ST_RUN : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rem_nxt = r_rem;
      w_quo_nxt = r_quo;
      w_sum     = '0;
      w_shift   = '0;
      w_sub     = '0;
      if (r_op == OP_MULT) begin
         // {rem, quo} is the product register; quo starts as the multiplier.
         w_sum     = r_rem + (r_quo[0] ? {1'b0, r_mag_a} : '0);
         w_rem_nxt = {1'b0, w_sum[WIDTH:1]};
         w_quo_nxt = {w_sum[0], r_quo[WIDTH-1:1]};
      end else begin
         w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
         w_sub   = {1'b0, w_shift} - {2'b00, r_mag_b};
         if (w_sub[WIDTH+1]) begin
            w_rem_nxt = w_shift;
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
         end else begin
            w_rem_nxt = w_sub[WIDTH:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
         end
      end
   end

   always_comb begin
      w_prod_mag = {w_rem_nxt[WIDTH-1:0], w_quo_nxt};
      w_prod     = r_neg ? $signed(-w_prod_mag) : $signed(w_prod_mag);
      w_quo_s    = r_neg ? -w_quo_nxt : w_quo_nxt;
      w_res_fin  = '0;
      w_exc_fin  = 1'b0;
      if (r_op == OP_MULT) begin
         w_res_fin = w_prod[WIDTH-1:0];
         w_exc_fin = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | (~|w_prod[2*WIDTH-1:WIDTH-1]));
      end else if (r_b_zero) begin
         w_exc_fin = 1'b1;
      end else if (r_ovf) begin
         w_res_fin = MIN_S;
         w_exc_fin = 1'b1;
      end else begin
         w_res_fin = w_quo_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op     <= OP_MULT;
         r_neg    <= 1'b0;
         r_b_zero <= 1'b0;
         r_ovf    <= 1'b0;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_result <= '0;
         r_exc    <= 1'b0;
      end else if (w_start) begin
         r_op     <= w_op_in;
         r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         r_b_zero <= (data_operandB == '0);
         r_ovf    <= (data_operandA == MIN_S) && (&data_operandB);
         r_mag_a  <= f_mag(data_operandA);
         r_mag_b  <= f_mag(data_operandB);
         r_rem    <= '0;
         r_quo    <= (w_op_in == OP_MULT) ? f_mag(data_operandB) : f_mag(data_operandA);
      end else if (r_state == ST_RUN) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         if (w_last) begin
            r_result <= w_res_fin;
            r_exc    <= w_exc_fin;
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;

endmodule
